div_iter: RTL and testbench
===========================

# div_iter

Iterative 64-bit radix-2 divider serving the execute-stage ALU over its `valid` / `data_ok` multi-cycle handshake. It accepts one divide request at a time and returns quotient and remainder for both signed and unsigned operands after a fixed latency. The ALU holds `valid` and stalls the pipeline until `data_ok` pulses. Sign handling, divide-by-zero and overflow results follow RISC-V M-extension semantics, so no post-correction is needed by the consumer.

## Interface
Parameters
- `WIDTH`, 64: operand and result width. Iteration count equals `WIDTH`.

Ports
- `clk`  in  1  clock. One clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `valid`  in  1  request. Sampled only in IDLE; held high by the ALU until `data_ok`.
- `is_signed`  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU. Sampled with `valid`.
- `srca`  in  WIDTH  dividend. Sampled with `valid`.
- `srcb`  in  WIDTH  divisor. Sampled with `valid`.
- `quot`  out  WIDTH  quotient, registered.
- `rem`  out  WIDTH  remainder, registered.
- `data_ok`  out  1  one-cycle pulse: `quot`/`rem` valid this cycle.

## Operation
- States: IDLE, BUSY, DONE. The reset state is IDLE.
- IDLE:
  - If `valid` is 0, hold.
  - If `valid` is 1 and `srcb`==0, go to DONE. Load `quot`=all-ones and `rem`=`srca`.
  - If `valid` is 1 and `srcb`!=0:
    - Latch the magnitudes |a| and |b|. Take the absolute value only when `is_signed` is 1 and the MSB is set.
    - Latch `neg_q` = signed & (a[MSB] ^ b[MSB]).
    - Latch `neg_r` = signed & a[MSB].
    - Clear the partial remainder. Set counter = 0. Go to BUSY.
- BUSY, one restoring step per cycle:
  - Shift {rem_acc, q_acc} left by one.
  - Trial-subtract |b| from the upper WIDTH+1 bits.
  - If the result is non-negative, keep the difference and set q bit to 1.
  - Increment the counter.
  - When the counter reaches WIDTH-1 during a step, go to DONE. On that transition:
    - `quot` = neg_q ? -q_acc : q_acc
    - `rem` = neg_r ? -rem_acc : rem_acc
- DONE:
  - `data_ok`=1 for exactly this cycle. `valid` is ignored. Go to IDLE unconditionally.
- Result stability: `quot`/`rem` hold their value from the DONE entry until the next DONE entry.
- Back-to-back requests: the next instruction's `valid` is high in the cycle after DONE. IDLE accepts it immediately.
- Overflow (signed, a=0x8000_0000_0000_0000, b=-1): the magnitude path yields q=2^63 and r=0. After negation, `quot`=0x8000…0 and `rem`=0. No special case is needed, but the bench must check it.
- Arithmetic widths:
  - The partial remainder is WIDTH+1 bits, so the trial subtraction is exact for |b| up to 2^63.
  - Negation is two's complement mod 2^WIDTH.
- Reset in any state:
  - Next state is IDLE. `data_ok`=0. `quot`=0, `rem`=0. Counter and accumulators are cleared.
  - An in-flight request is discarded and no `data_ok` is issued for it.
- Inputs are never re-sampled during BUSY. Operand changes mid-operation have no effect.

## Timing
- Reset values: `data_ok`=0, `quot`=0, `rem`=0, state IDLE.
- Call the cycle in which `valid` is sampled high in IDLE cycle 0.
- Non-zero divisor:
  - BUSY occupies cycles 1..WIDTH.
  - `data_ok` is high in cycle WIDTH+1 (cycle 65 for WIDTH=64).
  - Total latency is WIDTH+1 cycles.
- Zero divisor: `data_ok` is high in cycle 1.
- Throughput: a new request can be sampled in cycle WIDTH+2, the IDLE following DONE.
- `data_ok` is never high for two consecutive cycles.

## Test plan
- Unsigned: `srca`=100, `srcb`=7, `is_signed`=0, `valid` held. Expect `quot`=14 and `rem`=2 with `data_ok` exactly in cycle 65, low at all other times.
- Signed sign matrix, checking each pair:
  - (-7)/2 → `quot`=-3, `rem`=-1
  - 7/(-2) → `quot`=-3, `rem`=1
  - (-7)/(-2) → `quot`=3, `rem`=-1
- Boundaries:
  - Signed 0x8000…0 / -1 → `quot`=0x8000…0, `rem`=0.
  - Unsigned 0xFFFF…F / 1 → `quot`=0xFFFF…F, `rem`=0.
  - Unsigned 5 / 0xFFFF…F → `quot`=0, `rem`=5.
- Divide by zero: `srca`=42, `srcb`=0, for both signed and unsigned. Expect `data_ok` in cycle 1, `quot`=0xFFFF…F, `rem`=42.
- Back-to-back:
  - Hold `valid` high across 20/3 and then 9/4.
  - Expect `data_ok` at cycle 65 (6, 2) and again at cycle 131 (2, 1).
  - Confirm that operand changes during BUSY do not alter the first result.
- Reset mid-operation: assert `reset` at cycle 30 of a divide. Expect no `data_ok`, and `quot`=`rem`=0 next cycle. A fresh 50/5 request then yields 10 and 0 after 65 cycles.

Source files
------------

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Iterative radix-2 restoring divider returning quotient and
//                remainder with RISC-V M-extension signed/unsigned semantics.
//                Handshake: valid held by requester, data_ok one-cycle pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             data_ok
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] b_mag;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic             step_ok;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitudes: negate only signed operands with the MSB set.
    assign a_abs = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    assign b_abs = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

    // One restoring step. The shifted partial remainder is WIDTH+1 bits; the
    // difference always fits in WIDTH bits when the trial subtraction succeeds
    // because the result is then below |b|.
    assign shifted = {rem_acc, q_acc[WIDTH-1]};
    assign step_ok = (shifted >= {1'b0, b_mag});
    assign r_step  = step_ok ? (shifted[WIDTH-1:0] - b_mag) : shifted[WIDTH-1:0];
    assign q_step  = {q_acc[WIDTH-2:0], step_ok};
    assign q_final = neg_q ? -q_step : q_step;
    assign r_final = neg_r ? -r_step : r_step;

    assign data_ok = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nx = (srcb == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            q_acc   <= '0;
            rem_acc <= '0;
            b_mag   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            quot    <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (srcb == '0) begin
                            quot <= '1;
                            rem  <= srca;
                        end else begin
                            q_acc   <= a_abs;
                            b_mag   <= b_abs;
                            rem_acc <= '0;
                            cnt     <= '0;
                            neg_q   <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                            neg_r   <= is_signed & srca[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    q_acc   <= q_step;
                    rem_acc <= r_step;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quot <= q_final;
                        rem  <= r_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Directed self-checking bench for div_iter (WIDTH=64).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        reset;
    logic        valid;
    logic        is_signed;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic [63:0] quot;
    logic [63:0] rem;
    logic        data_ok;

    int errors;
    int checks;
    int cyc;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    div_iter #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .quot      (quot),
        .rem       (rem),
        .data_ok   (data_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Wait (sampling on falling edges) for data_ok; returns latency relative to start.
    task automatic wait_ok(input int start, input int limit, output int rel);
        rel = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (data_ok) begin
                rel = cyc - start;
                break;
            end
        end
    endtask

    // One complete request: drive, wait for data_ok, check latency and results.
    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input int exp_lat,
                       input logic [63:0] eq, input logic [63:0] er);
        int start;
        int rel;
        @(negedge clk);
        srca      = a;
        srcb      = b;
        is_signed = s;
        valid     = 1'b1;
        start     = cyc;
        wait_ok(start, 200, rel);
        check({tag, " latency"}, 64'(rel), 64'(exp_lat));
        check({tag, " quot"}, quot, eq);
        check({tag, " rem"}, rem, er);
        valid = 1'b0;
        @(negedge clk);
        check({tag, " pulse"}, {63'd0, data_ok}, 64'd0);
    endtask

    initial begin
        int start;
        int rel;
        bit seen;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        reset     = 1'b1;
        valid     = 1'b0;
        is_signed = 1'b0;
        srca      = '0;
        srcb      = '0;
        repeat (3) @(negedge clk);
        check("reset data_ok", {63'd0, data_ok}, 64'd0);
        check("reset quot", quot, 64'd0);
        check("reset rem", rem, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned basic and sign matrix.
        run("u100/7", 64'd100, 64'd7, 1'b0, 65, 64'd14, 64'd2);
        run("s-7/2", -64'sd7, 64'd2, 1'b1, 65, -64'sd3, ONES);
        run("s7/-2", 64'd7, -64'sd2, 1'b1, 65, -64'sd3, 64'd1);
        run("s-7/-2", -64'sd7, -64'sd2, 1'b1, 65, 64'd3, ONES);

        // Boundaries.
        run("ovf", MIN, ONES, 1'b1, 65, MIN, 64'd0);
        run("umax/1", ONES, 64'd1, 1'b0, 65, ONES, 64'd0);
        run("u5/max", 64'd5, ONES, 1'b0, 65, 64'd0, 64'd5);

        // Divide by zero.
        run("u42/0", 64'd42, 64'd0, 1'b0, 1, ONES, 64'd42);
        run("s42/0", 64'd42, 64'd0, 1'b1, 1, ONES, 64'd42);

        // Back-to-back with valid held and operands disturbed mid-operation.
        @(negedge clk);
        srca      = 64'd20;
        srcb      = 64'd3;
        is_signed = 1'b0;
        valid     = 1'b1;
        start     = cyc;
        repeat (10) @(negedge clk);
        srca = 64'd1000;
        srcb = 64'd1;
        wait_ok(start, 200, rel);
        check("b2b first latency", 64'(rel), 64'd65);
        check("b2b first quot", quot, 64'd6);
        check("b2b first rem", rem, 64'd2);
        srca = 64'd9;
        srcb = 64'd4;
        wait_ok(start, 200, rel);
        check("b2b second latency", 64'(rel), 64'd131);
        check("b2b second quot", quot, 64'd2);
        check("b2b second rem", rem, 64'd1);
        valid = 1'b0;
        @(negedge clk);
        check("b2b pulse", {63'd0, data_ok}, 64'd0);

        // Reset mid-operation.
        @(negedge clk);
        srca      = 64'd1000;
        srcb      = 64'd3;
        is_signed = 1'b0;
        valid     = 1'b1;
        start     = cyc;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check("rst data_ok", {63'd0, data_ok}, 64'd0);
        check("rst quot", quot, 64'd0);
        check("rst rem", rem, 64'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (data_ok) seen = 1'b1;
        end
        check("rst no data_ok", {63'd0, seen}, 64'd0);
        run("u50/5", 64'd50, 64'd5, 1'b0, 65, 64'd10, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
